// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared defaults, latency width helper and index/latency types for the hazard scoreboard
package hazard_pkg;

  localparam int NREG_DEF    = 32;
  localparam int MAX_LAT_DEF = 7;

  function automatic int lat_w(input int max_lat);
    return $clog2(max_lat + 1);
  endfunction

  typedef logic [$clog2(NREG_DEF)-1:0]   reg_idx_t;
  typedef logic [lat_w(MAX_LAT_DEF)-1:0] lat_t;

endpackage

// File: rtl/sb_entry.sv
// rtl/sb_entry.sv - per-register result countdown: load, saturating decrement, clear
module sb_entry #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic             busy,
  output logic             busy_gt1
);

  logic [LAT_W-1:0] cnt_q;

  // a new producer overrides the running countdown (in-order WAW)
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - LAT_W'(1);
    end
  end

  assign busy     = (cnt_q != '0);
  assign busy_gt1 = (cnt_q > LAT_W'(1));

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage RAW hazard scoreboard with per-register countdowns
// Optional stall statistics counters enabled by HAZARD_SCOREBOARD_STATS_EN.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG    = NREG_DEF,
  parameter int MAX_LAT = MAX_LAT_DEF,
  parameter int LAT_W   = lat_w(MAX_LAT),
  parameter int IDX_W   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [IDX_W-1:0] issue_rd,
  input  logic [LAT_W-1:0] issue_lat,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic [IDX_W-1:0] rs_id,
  input  logic [IDX_W-1:0] rt_id,
  input  logic             early_id,
  input  logic             flush,
`ifdef HAZARD_SCOREBOARD_STATS_EN
  output logic [31:0]      stall_cnt_o,
  output logic [31:0]      stall_early_cnt_o,
`endif
  output logic             stall_o,
  output logic             pc_ifwrite_o
);

  localparam logic [LAT_W-1:0] MAX_LAT_V = LAT_W'(MAX_LAT);

  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  busy_gt1;
  logic             rs_conflict;
  logic             rt_conflict;
  logic             accept;
  logic [LAT_W-1:0] load_val;

  assign busy[0]     = 1'b0;
  assign busy_gt1[0] = 1'b0;

  genvar r;
  generate
    for (r = 1; r < NREG; r++) begin : g_entry
      sb_entry #(
        .LAT_W(LAT_W)
      ) u_entry (
        .clk     (clk),
        .rst     (rst),
        .clr     (flush),
        .load    (accept && (issue_rd == IDX_W'(r))),
        .load_val(load_val),
        .busy    (busy[r]),
        .busy_gt1(busy_gt1[r])
      );
    end
  endgenerate

  // early resolvers need the value one cycle before normal EX consumers
  assign rs_conflict = early_id ? busy[rs_id] : busy_gt1[rs_id];
  assign rt_conflict = early_id ? busy[rt_id] : busy_gt1[rt_id];

  assign stall_o      = (use_rs && rs_conflict) || (use_rt && rt_conflict);
  assign pc_ifwrite_o = !stall_o;

  assign accept   = issue_valid && !stall_o && !flush && (issue_rd != '0);
  assign load_val = (issue_lat > MAX_LAT_V) ? MAX_LAT_V : issue_lat;

`ifdef HAZARD_SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_early_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q       <= '0;
      stall_early_cnt_q <= '0;
    end else if (stall_o) begin
      if (stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (early_id && (stall_early_cnt_q != '1)) begin
        stall_early_cnt_q <= stall_early_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt_o       = stall_cnt_q;
  assign stall_early_cnt_o = stall_early_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench for hazard_scoreboard
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  logic     clk = 1'b0;
  logic     rst;
  logic     issue_valid;
  reg_idx_t issue_rd;
  lat_t     issue_lat;
  logic     use_rs;
  logic     use_rt;
  reg_idx_t rs_id;
  reg_idx_t rt_id;
  logic     early_id;
  logic     flush;
  logic     stall_o;
  logic     pc_ifwrite_o;
`ifdef HAZARD_SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] stall_early_cnt_o;
`endif

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk              (clk),
    .rst              (rst),
    .issue_valid      (issue_valid),
    .issue_rd         (issue_rd),
    .issue_lat        (issue_lat),
    .use_rs           (use_rs),
    .use_rt           (use_rt),
    .rs_id            (rs_id),
    .rt_id            (rt_id),
    .early_id         (early_id),
    .flush            (flush),
`ifdef HAZARD_SCOREBOARD_STATS_EN
    .stall_cnt_o      (stall_cnt_o),
    .stall_early_cnt_o(stall_early_cnt_o),
`endif
    .stall_o          (stall_o),
    .pc_ifwrite_o     (pc_ifwrite_o)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          pend [NREG_DEF];
  logic        exp_q [$];
  int          nstall;
  logic [31:0] exp_cnt;
  logic [31:0] exp_ecnt;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic src_conflict(input reg_idx_t r, input logic early);
    if (r == 0) return 1'b0;
    return early ? (pend[r] > 0) : (pend[r] > 1);
  endfunction

  function automatic logic model_stall();
    return (use_rs && src_conflict(rs_id, early_id)) || (use_rt && src_conflict(rt_id, early_id));
  endfunction

  task automatic idle();
    rst = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_rd = '0; issue_lat = '0;
    use_rs = 1'b0; use_rt = 1'b0; rs_id = '0; rt_id = '0; early_id = 1'b0;
  endtask

  task automatic issue(input reg_idx_t rd, input lat_t lat);
    idle();
    issue_valid = 1'b1; issue_rd = rd; issue_lat = lat;
  endtask

  // one clock: push expectation, compare at the negedge, advance the model at the posedge
  task automatic cycle();
    logic e;
    exp_q.push_back(model_stall());
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check_vec("queue_underflow", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_vec("stall_o", {31'd0, stall_o}, {31'd0, e});
      check_vec("pc_ifwrite_o", {31'd0, pc_ifwrite_o}, {31'd0, !e});
    end
    if (stall_o === 1'b1) nstall++;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NREG_DEF; i++) pend[i] = 0;
      exp_cnt = '0; exp_ecnt = '0;
    end else begin
      if (e) begin
        if (exp_cnt != '1) exp_cnt++;
        if (early_id && exp_ecnt != '1) exp_ecnt++;
      end
      if (flush) begin
        for (int i = 0; i < NREG_DEF; i++) pend[i] = 0;
      end else begin
        for (int i = 0; i < NREG_DEF; i++) if (pend[i] > 0) pend[i]--;
        if (issue_valid && !e && issue_rd != 0)
          pend[issue_rd] = (int'(issue_lat) > MAX_LAT_DEF) ? MAX_LAT_DEF : int'(issue_lat);
      end
    end
    #1;
  endtask

  task automatic consume(input reg_idx_t r, input logic early, input int n, output int stalls);
    idle();
    use_rs = 1'b1; rs_id = r; early_id = early;
    nstall = 0;
    repeat (n) cycle();
    stalls = nstall;
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s;
    for (int i = 0; i < NREG_DEF; i++) pend[i] = 0;
    exp_cnt = '0; exp_ecnt = '0;
    idle();
    rst = 1'b1;
    cycle(); cycle();

    consume(5'd5, 1'b1, 2, s);
    check_vec("reset_no_stall", s, 0);

    issue(5'd5, 3'd2); cycle();
    consume(5'd5, 1'b0, 6, s);
    check_vec("load_use_stalls", s, 1);

    issue(5'd31, 3'd2); cycle();
    consume(5'd31, 1'b1, 6, s);
    check_vec("jr_early_stalls", s, 2);

    issue(5'd0, 3'd7); cycle();
    consume(5'd0, 1'b1, 6, s);
    check_vec("r0_never_stalls", s, 0);

    issue(5'd3, 3'd7); cycle();
    consume(5'd3, 1'b0, 10, s);
    check_vec("max_lat_stalls", s, 6);

    issue(5'd6, 3'd3); cycle();
    idle(); use_rt = 1'b1; rt_id = 5'd6; nstall = 0;
    repeat (4) cycle();
    check_vec("rt_stalls", nstall, 2);

    issue(5'd4, 3'd5); cycle();
    idle(); cycle();
    issue(5'd4, 3'd1); cycle();
    consume(5'd4, 1'b0, 4, s);
    check_vec("waw_no_stall", s, 0);

    issue(5'd0, 3'd0); issue_rd = 5'd9; cycle();
    consume(5'd9, 1'b1, 2, s);
    check_vec("lat0_no_stall", s, 0);

    issue(5'd7, 3'd3); cycle();
    idle(); flush = 1'b1; cycle();
    consume(5'd7, 1'b1, 4, s);
    check_vec("flush_clears", s, 0);

    issue(5'd8, 3'd3); flush = 1'b1; cycle();
    consume(5'd8, 1'b1, 4, s);
    check_vec("flush_blocks_issue", s, 0);

`ifdef HAZARD_SCOREBOARD_STATS_EN
    check_vec("stall_cnt_pre_rst", stall_cnt_o, exp_cnt);
    check_vec("stall_early_cnt_pre_rst", stall_early_cnt_o, exp_ecnt);
`endif

    issue(5'd7, 3'd3); cycle();
    issue(5'd9, 3'd3); rst = 1'b1; flush = 1'b1; cycle();
    consume(5'd7, 1'b1, 3, s);
    check_vec("rst_clears_r7", s, 0);
    consume(5'd9, 1'b1, 3, s);
    check_vec("rst_blocks_issue", s, 0);
`ifdef HAZARD_SCOREBOARD_STATS_EN
    check_vec("stall_cnt_after_rst", stall_cnt_o, 32'd0);
    check_vec("stall_early_cnt_after_rst", stall_early_cnt_o, 32'd0);
`endif

    for (int k = 0; k < 80; k++) begin
      idle();
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_rd    = reg_idx_t'($urandom_range(0, 7));
      issue_lat   = lat_t'($urandom_range(0, 7));
      use_rs      = ($urandom_range(0, 3) != 0);
      use_rt      = ($urandom_range(0, 1) == 1);
      rs_id       = reg_idx_t'($urandom_range(0, 7));
      rt_id       = reg_idx_t'($urandom_range(0, 7));
      early_id    = ($urandom_range(0, 3) == 0);
      flush       = ($urandom_range(0, 15) == 0);
      cycle();
    end
    idle();

`ifdef HAZARD_SCOREBOARD_STATS_EN
    check_vec("stall_cnt_random", stall_cnt_o, exp_cnt);
    check_vec("stall_early_cnt_random", stall_early_cnt_o, exp_ecnt);
    repeat (8) cycle();
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    exp_cnt = 32'hFFFF_FFFD;
    issue(5'd10, 3'd7); cycle();
    consume(5'd10, 1'b0, 8, s);
    check_vec("sat_stalls", s, 6);
    check_vec("stall_cnt_saturates", stall_cnt_o, 32'hFFFF_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
